// File: rtl/rr_arb8_pkg.sv
// ============================================================================
// Module      : rr_arb8_pkg
// Description : Shared state encoding and requester count for rr_arb8.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rr_arb8_pkg;

    localparam int N_REQ   = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb8_prio_enc8_rr.sv
// ============================================================================
// Module      : prio_enc8_rr
// Description : Rotated priority encoder; first set request at or above ptr.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prio_enc8_rr
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_valid_o
);

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        logic [IDX_W-1:0] idx;
        winner_o    = '0;
        any_valid_o = |req_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr_i + IDX_W'(i);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb8.sv
// ============================================================================
// Module      : rr_arb8
// Description : 8-way round-robin arbiter with hold limit and timeout pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o,
    output logic             timeout_o
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q,  state_d;
    logic [IDX_W-1:0]  ptr_q,    ptr_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [N_REQ-1:0]  grant_q,  grant_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              valid_q,  valid_d;
    logic              tmo_q,    tmo_d;

    logic [IDX_W-1:0]  enc_winner;
    logic              enc_any;
    logic              hold_hit;
    logic              holder_drop;

    prio_enc8_rr u_enc (
        .req_i       (req_i),
        .ptr_i       (ptr_q),
        .winner_o    (enc_winner),
        .any_valid_o (enc_any)
    );

    assign hold_hit    = (hold_q == HOLD_LAST);
    assign holder_drop = ~req_i[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_GRANT;
                    grant_d = onehot8(enc_winner);
                    idx_d   = enc_winner;
                    valid_d = 1'b1;
                    ptr_d   = enc_winner + IDX_W'(1);
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (done_i || holder_drop || hold_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    // Pulse only when the limit is the sole reason for release.
                    tmo_d   = hold_hit && !done_i && !holder_drop;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = valid_q;
    assign timeout_o     = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb8.sv
// ============================================================================
// Module      : tb_rr_arb8
// Description : Directed self-checking bench for rr_arb8 (MAX_HOLD = 4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rr_arb8 #(.MAX_HOLD(4)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .done_i        (done),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .timeout_o     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                             input logic v, input logic to);
        check_val({tag, ".grant"}, 32'(grant), 32'(g));
        check_val({tag, ".idx"},   32'(grant_idx), 32'(idx));
        check_val({tag, ".valid"}, 32'(grant_valid), 32'(v));
        check_val({tag, ".tmo"},   32'(timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'd1 << idx;
        check_out(tag, oh, idx, 1'b1, 1'b0);
    endtask

    task automatic check_idle(input string tag, input logic to);
        check_out(tag, 8'h00, 3'd0, 1'b0, to);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #12;
        check_idle("reset", 1'b0);
        step();
        rst = 1'b0;
        step();
        check_idle("idle_noreq", 1'b0);

        // done in IDLE is ignored
        done = 1'b1;
        step();
        check_idle("done_in_idle", 1'b0);

        // Rotation: all requesting, done held -> 0..7,0 with idle gaps
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_grant($sformatf("rot%0d", k), 3'(k % 8));
            if (k == 8) begin
                req  = 8'h00;
                done = 1'b0;
            end
            step();
            check_idle($sformatf("rot_gap%0d", k), 1'b0);
        end

        // Pointer wrap: ptr=1 now; grant 6 sets ptr 7
        req = 8'h40;
        step();
        check_grant("wrap_g6", 3'd6);
        req = 8'h00;
        step();
        check_idle("wrap_gap0", 1'b0);
        req = 8'h41;
        step();
        check_grant("wrap_g0", 3'd0);
        req = 8'h00;
        step();
        check_idle("wrap_gap1", 1'b0);
        req = 8'h41;
        step();
        check_grant("wrap_g6b", 3'd6);
        req = 8'h00;
        step();
        check_idle("wrap_gap2", 1'b0);

        // Request drop: ptr=7, grant 2, then drop bit 2 with bit 4 set
        req = 8'h04;
        step();
        check_grant("drop_g2", 3'd2);
        req = 8'h10;
        step();
        check_idle("drop_rel", 1'b0);
        step();
        check_grant("drop_g4", 3'd4);
        req = 8'h00;
        step();
        check_idle("drop_gap", 1'b0);

        // Timeout: ptr=5, req 0x08 held -> 4 grant cycles, pulse, regrant
        req = 8'h08;
        step();
        for (int c = 0; c < 4; c++) begin
            check_grant($sformatf("hold%0d", c), 3'd3);
            step();
        end
        check_idle("timeout_pulse", 1'b1);
        step();
        check_grant("regrant3", 3'd3);

        // Coincidence: done in 4th grant cycle suppresses timeout
        step();
        check_grant("coin_c2", 3'd3);
        step();
        check_grant("coin_c3", 3'd3);
        step();
        check_grant("coin_c4", 3'd3);
        done = 1'b1;
        step();
        check_idle("coin_rel", 1'b0);
        done = 1'b0;
        req  = 8'h00;
        step();
        check_idle("coin_after", 1'b0);

        // Reset mid-grant of requester 5 (ptr=4)
        req = 8'h20;
        step();
        check_grant("pre_rst_g5", 3'd5);
        step();
        check_grant("pre_rst_hold", 3'd5);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst", 1'b0);
        step();
        check_idle("rst_held", 1'b0);
        rst = 1'b0;
        step();
        check_out("post_rst_g5", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h00;
        step();
        check_idle("post_rst_rel", 1'b0);

        // After reset the pointer restarts at 0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 8'hFF;
        step();
        check_grant("ptr0_after_rst", 3'd0);
        req = 8'h00;
        step();
        check_idle("final_idle", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
